stage_if_fetch: RTL and testbench
=================================

# stage_if_fetch

Instruction-fetch stage of the five-stage MIPS pipeline: owns the program counter, drives the instruction-bus read handshake, and presents `if_register_pc_read_data` / `if_instruction` to the IF/ID pipeline latch. It honours the shared `stall[5:0]` vector and requests a pipeline stall while a fetch is outstanding. It also buffers a fetched word while IF is stalled, remembers branch redirects that arrive during a stall, and applies exception flushes.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded by reset.
- `clock` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 6: pipeline stall vector; this block uses `stall[0]` (freeze IF).
- `stall_request` out 1: to stall controller; high while IF cannot deliver.
- `branch_enable` in 1: ID-stage branch/jump taken.
- `branch_target` in 32: ID-stage target address.
- `flush` in 1: exception/eret redirect, highest priority after reset.
- `flush_pc` in 32: redirect address.
- `ibus_request` out 1: read request.
- `ibus_address` out 32: word address of request.
- `ibus_ready` in 1: read completes this cycle, data valid.
- `ibus_read_data` in 32: instruction word.
- `if_register_pc_read_data` out 32: PC of the delivered instruction.
- `if_instruction` out 32: delivered instruction; 0 (NOP bubble) when none.

## Operation
- Registers: `pc`, `state`, `hold_data`, `old_addr`, `pend_valid`, `pend_target`.
- States:
  - FETCH: request at `pc`.
  - HOLD: word buffered, waiting for `stall[0]` low.
  - DISCARD: completing an abandoned request.
- Bus rule: once `ibus_request` is high, `ibus_address` must stay constant until the cycle `ibus_ready` is high. Requests are never withdrawn.
- FETCH:
  - `ibus_request`=1, `ibus_address`=`pc`.
  - `if_instruction` = `ibus_ready ? ibus_read_data : 0`.
  - `stall_request` = `~ibus_ready`.
  - ready & `stall[0]`=0: advance PC, stay FETCH.
  - ready & `stall[0]`=1: `hold_data`<=data, go HOLD.
- HOLD:
  - `ibus_request`=0, `if_instruction`=`hold_data`, `stall_request`=0.
  - `stall[0]`=0: advance PC, go FETCH.
- DISCARD:
  - `ibus_request`=1, `ibus_address`=`old_addr`.
  - `if_instruction`=0, `stall_request`=1.
  - On ready: go FETCH; data dropped.
- `if_register_pc_read_data` = `pc` in every state; in DISCARD it is the already-redirected `pc`.
- Advance PC, next value in priority order:
  1. `branch_target` if `branch_enable`.
  2. `pend_target` if `pend_valid`.
  3. `pc`+4, wrapping mod 2^32.
  - Every advance clears `pend_valid`.
- Pending branch: on any edge with `branch_enable`=1 and no advance, set `pend_valid`=1 and `pend_target`=`branch_target`. Repeated assertion while ID is held is idempotent.
- Flush, evaluated before all of the above:
  - `pc`<=`flush_pc`; `pend_valid`<=0; `hold_data` is discarded.
  - In FETCH with `ibus_ready`=0: `old_addr`<=`pc`, go DISCARD.
  - In FETCH with `ibus_ready`=1: go FETCH.
  - In HOLD: go FETCH.
  - In DISCARD: stay DISCARD, `old_addr` unchanged.
- `stall[5:1]` are ignored; the IF/ID latch handles them.

## Timing
- Reset, at the edge with `reset`=1:
  - `pc`=`RESET_PC`, state=FETCH, `pend_valid`=0, `hold_data`=0, `old_addr`=0.
  - While `reset` is high: `ibus_request`=0, `stall_request`=0, `if_instruction`=0.
- Reset mid-transaction abandons the request immediately. The bus slave must itself be reset by the same `reset`.
- Zero-wait bus (ready in the request cycle): one instruction per clock; `if_instruction` is combinational from `ibus_read_data`.
- N wait cycles: `stall_request` is high for N cycles, then the instruction is delivered.
- Delay slot: the fetch in flight when `branch_enable` rises is delivered normally. The next request goes to the target.
- Simultaneous `flush` and `branch_enable`: flush wins and the branch is dropped.
- Simultaneous `flush` and `reset`: reset wins.

## Test plan
- Zero-wait bus, `RESET_PC`=0, no stalls, 4 cycles after reset -> addresses 0,4,8,C on consecutive cycles. Each `if_instruction` equals the bus data and `stall_request` never rises.
- `ibus_ready` delayed 2 cycles on address 4 -> `stall_request`=1 for exactly 2 cycles with `ibus_address` held at 4. The word is delivered in cycle 3 and the next address is 8.
- Ready on address 8 while `stall[0]`=1 for 3 cycles -> HOLD, `ibus_request`=0, `if_instruction`=buffered word for 3 cycles. Then address C is requested.
- `branch_enable`=1 with target 0x100 during the delay-slot fetch at 8, which waits 2 cycles; ID is bubbled so `branch_enable` drops after one cycle -> slot at 8 is delivered, then fetch 0x100, not C.
- `flush`=1 with `flush_pc`=0x180 while fetch at 0x10 is waiting -> request at 0x10 is kept until ready, its data is dropped, and `if_instruction`=0. The next request is to 0x180 with `if_register_pc_read_data`=0x180.
- `reset` pulsed while HOLD and pending branch are set -> next cycle request at `RESET_PC`, `pend_valid`=0, no stale branch taken. PC 0xFFFFFFFC advances to 0.

Source files
------------

// File: rtl/stage_if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the instruction-bus
// read handshake and feeds the IF/ID latch.
//
// Ports:
//   clock, reset            - single clock, synchronous active-high reset
//   stall[5:0]              - stall vector; only stall[0] freezes IF
//   stall_request           - high while IF cannot deliver a word
//   branch_enable/_target   - taken branch/jump from ID
//   flush/flush_pc          - exception/eret redirect
//   ibus_request/_address   - instruction read request
//   ibus_ready/_read_data   - read completion and instruction word
//   if_register_pc_read_data, if_instruction - to IF/ID latch
module stage_if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  stall,
    output logic        stall_request,
    input  logic        branch_enable,
    input  logic [31:0] branch_target,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        ibus_request,
    output logic [31:0] ibus_address,
    input  logic        ibus_ready,
    input  logic [31:0] ibus_read_data,
    output logic [31:0] if_register_pc_read_data,
    output logic [31:0] if_instruction
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic [31:0] old_addr_q, old_addr_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic        advance;
    logic [31:0] pc_next;

    wire unused_stall = ^stall[5:1];

    // Branch from ID beats an older remembered redirect.
    always_comb begin
        if (branch_enable)
            pc_next = branch_target;
        else if (pend_valid_q)
            pc_next = pend_target_q;
        else
            pc_next = pc_q + 32'd4;
    end

    always_comb begin
        ibus_request   = 1'b0;
        ibus_address   = pc_q;
        if_instruction = 32'd0;
        stall_request  = 1'b0;
        if (!reset) begin
            unique case (state_q)
                S_FETCH: begin
                    ibus_request   = 1'b1;
                    if_instruction = ibus_ready ? ibus_read_data : 32'd0;
                    stall_request  = ~ibus_ready;
                end
                S_HOLD: begin
                    if_instruction = hold_data_q;
                end
                S_DISCARD: begin
                    ibus_request  = 1'b1;
                    ibus_address  = old_addr_q;
                    stall_request = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign if_register_pc_read_data = pc_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_data_d   = hold_data_q;
        old_addr_d    = old_addr_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        advance       = 1'b0;
        if (flush) begin
            pc_d         = flush_pc;
            pend_valid_d = 1'b0;
            unique case (state_q)
                S_FETCH: begin
                    // A request already on the bus must still complete.
                    if (!ibus_ready) begin
                        old_addr_d = pc_q;
                        state_d    = S_DISCARD;
                    end
                end
                S_HOLD:    state_d = S_FETCH;
                S_DISCARD: state_d = S_DISCARD;
                default:   state_d = S_FETCH;
            endcase
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (ibus_ready) begin
                        if (!stall[0]) begin
                            advance = 1'b1;
                        end else begin
                            hold_data_d = ibus_read_data;
                            state_d     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall[0]) begin
                        advance = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_DISCARD: begin
                    if (ibus_ready)
                        state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
            if (advance) begin
                pc_d         = pc_next;
                pend_valid_d = 1'b0;
            end else if (branch_enable) begin
                // Remember a redirect that arrived while IF could not move.
                pend_valid_d  = 1'b1;
                pend_target_d = branch_target;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            hold_data_q   <= 32'd0;
            old_addr_q    <= 32'd0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_data_q   <= hold_data_d;
            old_addr_q    <= old_addr_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

endmodule

// File: tb/tb_stage_if_fetch.sv
// Directed bench for stage_if_fetch.
// Bus data = address + 0x1000_0000.
module tb_stage_if_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  stall;
    logic        stall_request;
    logic        branch_enable;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] flush_pc;
    logic        ibus_request;
    logic [31:0] ibus_address;
    logic        ibus_ready;
    logic [31:0] ibus_read_data;
    logic [31:0] if_register_pc_read_data;
    logic [31:0] if_instruction;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    assign ibus_read_data = ibus_address + 32'h1000_0000;

    stage_if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .stall                    (stall),
        .stall_request            (stall_request),
        .branch_enable            (branch_enable),
        .branch_target            (branch_target),
        .flush                    (flush),
        .flush_pc                 (flush_pc),
        .ibus_request             (ibus_request),
        .ibus_address             (ibus_address),
        .ibus_ready               (ibus_ready),
        .ibus_read_data           (ibus_read_data),
        .if_register_pc_read_data (if_register_pc_read_data),
        .if_instruction           (if_instruction)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then settle.
    task automatic step(input logic r, input logic rdy,
                        input logic st0, input logic be,
                        input logic [31:0] bt, input logic fl,
                        input logic [31:0] fpc);
        @(negedge clock);
        reset         = r;
        ibus_ready    = rdy;
        stall         = {5'b10101, st0};
        branch_enable = be;
        branch_target = bt;
        flush         = fl;
        flush_pc      = fpc;
        #1;
    endtask

    // Zero-wait fetch: check address, data and no stall.
    task automatic fetch_ok(input string tag, input logic [31:0] a);
        step(0, 1, 0, 0, 0, 0, 0);
        chk({tag, "_req"}, {31'd0, ibus_request}, 32'd1);
        chk({tag, "_adr"}, ibus_address, a);
        chk({tag, "_ins"}, if_instruction, a + 32'h1000_0000);
        chk({tag, "_stl"}, {31'd0, stall_request}, 32'd0);
    endtask

    task automatic do_reset();
        step(1, 1, 0, 0, 0, 0, 0);
        chk("rst_req", {31'd0, ibus_request}, 32'd0);
        chk("rst_stl", {31'd0, stall_request}, 32'd0);
        chk("rst_ins", if_instruction, 32'd0);
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        ibus_ready = 1'b0;
        stall = 6'd0;
        branch_enable = 1'b0;
        branch_target = 32'd0;
        flush = 1'b0;
        flush_pc = 32'd0;

        // Zero-wait streaming
        do_reset();
        fetch_ok("zw0", 32'h0);
        chk("zw0_pc", if_register_pc_read_data, 32'h0);
        fetch_ok("zw4", 32'h4);
        fetch_ok("zw8", 32'h8);
        fetch_ok("zwC", 32'hC);

        // Two wait cycles on address 4
        do_reset();
        fetch_ok("w0", 32'h0);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            chk("wt_stl", {31'd0, stall_request}, 32'd1);
            chk("wt_adr", ibus_address, 32'h4);
            chk("wt_ins", if_instruction, 32'd0);
        end
        fetch_ok("w4", 32'h4);

        // Ready on 8 while IF stalled, then 3 HOLD cycles
        step(0, 1, 1, 0, 0, 0, 0);
        chk("h8_ins", if_instruction, 32'h1000_0008);
        chk("h8_stl", {31'd0, stall_request}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, (i < 2), 0, 0, 0, 0);
            chk("hold_req", {31'd0, ibus_request}, 32'd0);
            chk("hold_ins", if_instruction, 32'h1000_0008);
            chk("hold_stl", {31'd0, stall_request}, 32'd0);
        end
        fetch_ok("hC", 32'hC);

        // Branch during delay-slot fetch at 8 (two waits)
        do_reset();
        fetch_ok("b0", 32'h0);
        fetch_ok("b4", 32'h4);
        step(0, 0, 0, 1, 32'h100, 0, 0);
        chk("ds_adr0", ibus_address, 32'h8);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("ds_adr1", ibus_address, 32'h8);
        fetch_ok("ds8", 32'h8);
        fetch_ok("tgt", 32'h100);
        chk("tgt_pc", if_register_pc_read_data, 32'h100);
        fetch_ok("tgt4", 32'h104);

        // Flush while fetch at 0x10 waits
        do_reset();
        fetch_ok("f0", 32'h0);
        fetch_ok("f4", 32'h4);
        fetch_ok("f8", 32'h8);
        fetch_ok("fC", 32'hC);
        step(0, 0, 0, 0, 0, 1, 32'h180);
        chk("fl_adr", ibus_address, 32'h10);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("dis_adr", ibus_address, 32'h10);
        chk("dis_req", {31'd0, ibus_request}, 32'd1);
        chk("dis_pc", if_register_pc_read_data, 32'h180);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("dis_ins", if_instruction, 32'd0);
        chk("dis_stl", {31'd0, stall_request}, 32'd1);
        chk("dis_adr2", ibus_address, 32'h10);
        step(0, 1, 1, 0, 0, 0, 0);
        chk("f180_adr", ibus_address, 32'h180);
        chk("f180_pc", if_register_pc_read_data, 32'h180);
        chk("f180_ins", if_instruction, 32'h1000_0180);

        // Pending branch in HOLD, then reset
        step(0, 0, 1, 1, 32'h200, 0, 0);
        chk("hp_ins", if_instruction, 32'h1000_0180);
        step(1, 1, 1, 0, 0, 0, 0);
        chk("rh_req", {31'd0, ibus_request}, 32'd0);
        chk("rh_ins", if_instruction, 32'd0);
        fetch_ok("r0", 32'h0);
        fetch_ok("r4", 32'h4);

        // Flush beats branch; PC wraps
        step(0, 1, 0, 1, 32'h300, 1, 32'hFFFF_FFFC);
        fetch_ok("wrapF", 32'hFFFF_FFFC);
        fetch_ok("wrap0", 32'h0);
        fetch_ok("wrap4", 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
